// File: rtl/gray_seq_ctrl_if.sv
// gray_seq_ctrl_if: request, burst and counter-side signals of the Gray counter
// sequencer. The master side holds the requesters and the counter readback;
// the slave side is the sequencer itself.
interface gray_seq_ctrl_if;
    localparam int NREQ = 2;

    logic [NREQ-1:0] req;
    logic [3:0]      len0;
    logic [3:0]      len1;
    logic            clr0;
    logic            clr1;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            cnt_en;
    logic            cnt_rst;
    logic [3:0]      gray_in;
    logic            gray_err;
    logic            busy;

    modport master (
        output req, len0, len1, clr0, clr1, gray_in,
        input  gnt, done, cnt_en, cnt_rst, gray_err, busy
    );

    modport slave (
        input  req, len0, len1, clr0, clr1, gray_in,
        output gnt, done, cnt_en, cnt_rst, gray_err, busy
    );
endinterface

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: round-robin arbiter and burst sequencer for a shared 4-bit
// Gray counter. A granted requester gets an optional counter clear followed
// by N enable pulses spaced two cycles apart; each SETTLE cycle reads the
// counter back. With GRAY_SEQ_CHECK_EN defined, the readback is checked for
// single-bit Gray steps and a sticky gray_err is raised on any other change.
// Without GRAY_SEQ_CHECK_EN, gray_err is tied low and the timing is unchanged.
module gray_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    gray_seq_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_PULSE  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [4:0] remain_r;
    logic [4:0] remain_nxt_s;
    logic       gsel_r;
    logic       gsel_nxt_s;
    logic       prio_r;
    logic       prio_nxt_s;
    logic       grant_s;
    logic       clr_sel_s;
    logic [3:0] len_sel_s;
    logic [1:0] gnt_r;
    logic [1:0] done_r;
    logic       cnt_en_r;
    logic       cnt_rst_r;
    logic       busy_r;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Next-state, arbitration and step-count decisions
    always_comb begin
        state_nxt_s  = state_r;
        remain_nxt_s = remain_r;
        gsel_nxt_s   = gsel_r;
        prio_nxt_s   = prio_r;
        grant_s      = 1'b0;
        clr_sel_s    = 1'b0;
        len_sel_s    = 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req != 2'b00) begin
                    grant_s    = 1'b1;
                    // The pointer names the preferred requester; fall back to the other.
                    gsel_nxt_s = bus.req[prio_r] ? prio_r : ~prio_r;
                    len_sel_s  = gsel_nxt_s ? bus.len1 : bus.len0;
                    clr_sel_s  = gsel_nxt_s ? bus.clr1 : bus.clr0;
                    // A length of zero encodes a full 16-step lap.
                    remain_nxt_s = (len_sel_s == 4'd0) ? 5'd16 : {1'b0, len_sel_s};
                    state_nxt_s  = clr_sel_s ? ST_CLEAR : ST_PULSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_PULSE;
            end
            ST_PULSE: begin
                state_nxt_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                remain_nxt_s = remain_r - 5'd1;
                if (remain_r == 5'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_PULSE;
                end
            end
            ST_DONE: begin
                prio_nxt_s  = ~gsel_r;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            remain_r  <= 5'd0;
            gsel_r    <= 1'b0;
            prio_r    <= 1'b0;
            gnt_r     <= 2'b00;
            done_r    <= 2'b00;
            cnt_en_r  <= 1'b0;
            cnt_rst_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            remain_r  <= remain_nxt_s;
            gsel_r    <= gsel_nxt_s;
            prio_r    <= prio_nxt_s;
            gnt_r     <= (state_nxt_s != ST_IDLE) ? idx_onehot(gsel_nxt_s) : 2'b00;
            done_r    <= (state_nxt_s == ST_DONE) ? idx_onehot(gsel_r) : 2'b00;
            cnt_en_r  <= (state_nxt_s == ST_PULSE);
            cnt_rst_r <= (state_nxt_s == ST_CLEAR);
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.done    = done_r;
    assign bus.cnt_en  = cnt_en_r;
    assign bus.cnt_rst = cnt_rst_r;
    assign bus.busy    = busy_r;

`ifdef GRAY_SEQ_CHECK_EN
    logic [3:0] prev_r;
    logic       gray_err_r;

    // True when a and b differ in exactly one bit position.
    function automatic logic is_gray_step(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        x = a ^ b;
        return (x != 4'd0) && ((x & (x - 4'd1)) == 4'd0);
    endfunction

    // Track the last counter value and latch any non-single-bit transition
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_r     <= 4'd0;
            gray_err_r <= 1'b0;
        end else if (grant_s && !clr_sel_s) begin
            prev_r <= bus.gray_in;
        end else if (state_r == ST_CLEAR) begin
            prev_r <= 4'd0;
        end else if (state_r == ST_SETTLE) begin
            if (!is_gray_step(prev_r, bus.gray_in)) begin
                gray_err_r <= 1'b1;
            end
            prev_r <= bus.gray_in;
        end
    end

    assign bus.gray_err = gray_err_r;
`else
    assign bus.gray_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed and randomized bursts against a behavioural
// Gray counter, checked with an arithmetic reference model of the arbiter
// (round-robin pointer), burst timing and counter position.
`timescale 1ns/1ps
module tb_gray_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gray_seq_ctrl_if bus();
    gray_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural counter; inj_arm makes one bad jump from binary 2 to 7
    // (Gray 0011 -> 0100) to provoke the transition checker.
    logic [3:0] ctr_bin = 4'd0;
    logic       inj_arm = 1'b0;
    always @(posedge clk) begin
        if (bus.cnt_rst === 1'b1) begin
            ctr_bin <= 4'd0;
        end else if (bus.cnt_en === 1'b1) begin
            if (inj_arm && ctr_bin == 4'd2) ctr_bin <= 4'd7;
            else                            ctr_bin <= ctr_bin + 4'd1;
        end
    end
    assign bus.gray_in = ctr_bin ^ (ctr_bin >> 1);

    // Reference model state
    int       m_prio = 0;
    int       m_bin  = 0;
    bit       m_err  = 1'b0;

    function automatic logic [3:0] gray_of(input int b);
        logic [3:0] v;
        v = 4'(b % 16);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, 32'({bus.gnt, bus.done, bus.cnt_en, bus.cnt_rst, bus.busy, bus.gray_err}), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst = 1'b1;
        m_prio = 0;
        m_err  = 1'b0;
    endtask

    // Present req_v, predict the winner from the model, then observe the whole burst.
    task automatic serve(input logic [1:0] req_v, input bit drop, input bit b2b, input bit inj);
        int g, n, clr, cyc, idx, n_en, n_rst, last_en, end_bin;
        bit space_ok, hold_ok;
        logic [1:0] oh;
        logic [3:0] len_g;
        g     = req_v[m_prio] ? m_prio : 1 - m_prio;
        oh    = (g == 1) ? 2'b10 : 2'b01;
        len_g = (g == 1) ? bus.len1 : bus.len0;
        n     = (len_g == 4'd0) ? 16 : int'(len_g);
        clr   = (g == 1) ? int'(bus.clr1) : int'(bus.clr0);
        end_bin = ((clr != 0) ? 0 : m_bin) + n + (inj ? 4 : 0);
        inj_arm = inj;
        bus.req = req_v;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.gnt == 2'b00 && cyc < 20);
        check("grant", 32'(bus.gnt), 32'(oh));
        if (b2b) check("idle_gap", 32'(cyc - 1), 32'd1);
        if (drop) bus.req = 2'b00;
        idx = 0; n_en = 0; n_rst = 0; last_en = -10; space_ok = 1'b1; hold_ok = 1'b1;
        while (bus.done == 2'b00 && idx < 40) begin
            if (bus.cnt_en === 1'b1) begin
                if (n_en > 0 && idx - last_en != 2) space_ok = 1'b0;
                last_en = idx;
                n_en++;
            end
            if (bus.cnt_rst === 1'b1) n_rst++;
            if (bus.gnt !== oh || bus.busy !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
            idx++;
        end
        check("latency",     32'(idx), 32'(2 * n + clr));
        check("done",        32'(bus.done), 32'(oh));
        check("gnt_at_done", 32'({bus.gnt, bus.busy, bus.cnt_en}), 32'({oh, 1'b1, 1'b0}));
        check("pulses",      32'(n_en), 32'(n));
        check("clears",      32'(n_rst), 32'(clr));
        check("spacing",     32'(space_ok), 32'd1);
        check("gnt_hold",    32'(hold_ok), 32'd1);
        check("gray_end",    32'(bus.gray_in), 32'(gray_of(end_bin)));
`ifdef GRAY_SEQ_CHECK_EN
        if (inj) m_err = 1'b1;
`endif
        check("gray_err",    32'(bus.gray_err), 32'(m_err));
        m_bin   = end_bin % 16;
        m_prio  = 1 - g;
        inj_arm = 1'b0;
    endtask

    initial begin
        int cyc, n_done;
        bus.req = 2'b00; bus.len0 = 4'd0; bus.len1 = 4'd0; bus.clr0 = 1'b0; bus.clr1 = 1'b0;
        @(negedge clk);
        do_reset();

        // Cleared 3-step burst: Gray 0 -> 1 -> 3 -> 2.
        bus.len0 = 4'd3; bus.clr0 = 1'b1;
        serve(2'b01, 1'b0, 1'b0, 1'b0);

        // Both requesting with single steps: grants alternate.
        bus.len0 = 4'd1; bus.len1 = 4'd1; bus.clr0 = 1'b0; bus.clr1 = 1'b0;
        serve(2'b11, 1'b0, 1'b1, 1'b0);
        serve(2'b11, 1'b0, 1'b1, 1'b0);
        serve(2'b11, 1'b0, 1'b1, 1'b0);

        // Full 16-step lap from a cleared counter, crossing 1000 -> 0000.
        bus.len0 = 4'd0; bus.clr0 = 1'b1;
        serve(2'b01, 1'b0, 1'b1, 1'b0);
        bus.len1 = 4'd0; bus.clr1 = 1'b0;
        serve(2'b10, 1'b0, 1'b1, 1'b0);

        // Injected 0011 -> 0100 jump; the error must stay set afterwards.
        bus.len0 = 4'd4; bus.clr0 = 1'b1;
        serve(2'b01, 1'b0, 1'b1, 1'b1);

        // Random bursts, sometimes dropping req after the grant.
        for (int i = 0; i < 10; i++) begin
            bus.len0 = 4'($urandom_range(0, 15));
            bus.len1 = 4'($urandom_range(0, 15));
            bus.clr0 = 1'($urandom_range(0, 1));
            bus.clr1 = 1'($urandom_range(0, 1));
            serve(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        // Serve requester 0, then abort requester 1's 5-step burst on its first pulse.
        bus.len0 = 4'd2; bus.clr0 = 1'b0;
        serve(2'b01, 1'b0, 1'b1, 1'b0);
        bus.len1 = 4'd5; bus.clr1 = 1'b0;
        bus.req  = 2'b10;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.cnt_en !== 1'b1 && cyc < 10);
        check("abort_pulse_seen", 32'(bus.cnt_en), 32'd1);
        rst = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
        m_bin = (m_bin + 1) % 16;
        check_idle_outputs("abort_outputs");
        rst = 1'b1;
        m_prio = 0;
        m_err  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done != 2'b00 || bus.gnt != 2'b00) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_counter_kept", 32'(bus.gray_in), 32'(gray_of(m_bin)));

        // After reset the pointer favours requester 0.
        bus.len0 = 4'd2; bus.len1 = 4'd3; bus.clr0 = 1'b0; bus.clr1 = 1'b1;
        serve(2'b11, 1'b0, 1'b0, 1'b0);
        serve(2'b11, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
